mc_controller_p: RTL
====================

Name: mc_controller_p

Overview:
- Parametrised multicycle control unit for the 8-bit MIPS datapath.
- Fetches an instruction over FETCH_BEATS byte reads, then decodes and sequences execution.
- Drives every datapath mux, write-enable and ALU control signal, including the gated PC enable.
- Adds over the previous controller: configurable fetch width, memory-ready stall handshake, ADDI, illegal-opcode flag, optional BNE.

Parameters:
FETCH_BEATS, 4, bytes per instruction fetch; legal 1..8; sets irwrite width and the fetch beat counter.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read or write this cycle
op  in  6  instruction opcode field
funct  in  6  R-type function field
memread  out  1  memory read request
memtoreg  out  1  register write data select: 1 = memory data, 0 = ALUOut
memwrite  out  1  memory write request
iord  out  1  address select: 0 = PC, 1 = ALUOut
alusrcA  out  1  ALU A select: 0 = PC, 1 = regA
regwrite  out  1  register file write enable
regdst  out  1  destination register select: 1 = rd, 0 = rt
pcen  out  1  PC register enable
alusrcB  out  2  ALU B select: 00 = regB, 01 = constant 1, 10 = immediate, 11 = immediate<<2
pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  3  ALU operation
irwrite  out  FETCH_BEATS  one-hot instruction-byte write enable
illegal  out  1  one-cycle pulse on an unknown opcode

Behaviour:
- Reset: state <= FETCH, beat counter <= 0. While reset is high, every output is 0. Reset mid-instruction aborts the instruction with no further writes.
- Outputs are Moore functions of the state, except these, which also depend on mem_ready / zero:
  - irwrite, pcwrite during fetch
  - memread-to-advance
  - pcen
- pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
- ALU decode:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, J 000010, ADDI 001000, BNE 000101 (optional).
- States, with asserted signals and transitions:
  - FETCH (beat k):
    - memread=1, iord=0, alusrcA=0, alusrcB=01, aluop=00, pcsrc=00.
    - When mem_ready=1: irwrite[k]=1 and pcwrite=1. If k = FETCH_BEATS-1, go to DECODE with k <= 0; otherwise k <= k+1.
    - When mem_ready=0: irwrite=0, pcwrite=0, hold.
  - DECODE:
    - alusrcA=0, alusrcB=11, aluop=00.
    - Next state: LB/SB -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; BNE -> BNEEX; ADDI -> ADDIEX; J -> JEX.
    - Any other opcode: illegal=1 for this cycle, then FETCH.
  - MEMADR: alusrcA=1, alusrcB=10, aluop=00. LB -> MEMRD; SB -> MEMWR.
  - MEMRD: memread=1, iord=1; hold until mem_ready=1, then MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: memwrite=1, iord=1; hold until mem_ready=1, then FETCH.
  - RTYPEEX: alusrcA=1, alusrcB=00, aluop=10 -> RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BEQEX: alusrcA=1, alusrcB=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - BNEEX: as BEQEX but branch_ne=1 instead of branch -> FETCH.
  - ADDIEX: alusrcA=1, alusrcB=10, aluop=00 -> ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JEX: pcsrc=10, pcwrite=1 -> FETCH.
- Cycle counts with no stalls, where F = FETCH_BEATS:
  - LB: F+4.
  - SB, RTYPE, ADDI: F+3.
  - BEQ, BNE, J: F+2.
  - Each mem_ready=0 cycle adds exactly one cycle.
- Boundary conditions:
  - FETCH_BEATS=1: a single fetch state; irwrite is 1 bit.
  - The beat counter never exceeds FETCH_BEATS-1.
  - mem_ready is ignored in states that do not access memory.
  - Unused outputs are 0 in every state.

Optional Feature:
CTRL_BNE_EN:
- Defined: opcode 000101 decodes to BNEEX; PC is taken when zero=0.
- Undefined: BNEEX state and the branch_ne term are absent; 000101 is illegal (illegal pulse, return to FETCH).

Test Plan:
- Reset held 2 cycles, released, mem_ready=1: all outputs 0 during reset; irwrite = 0001, 0010, 0100, 1000 on consecutive cycles; pcen=1 on each of those 4 cycles; DECODE on cycle 5.
- LB (op=100000), mem_ready=1 -> MEMRD has memread=1, iord=1; MEMWB has regwrite=1, memtoreg=1; total 8 cycles with F=4.
- RTYPE with funct=101010 -> alucontrol=111 in RTYPEEX; regdst=1, regwrite=1 next cycle. funct=111111 -> alucontrol=010.
- BEQ with zero=1 -> pcen=1 and pcsrc=01 in BEQEX; with zero=0 -> pcen=0. BNE (macro on), zero=0 -> pcen=1.
- SB with mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles, then FETCH; irwrite stays 0 during a fetch stall.
- op=111111 -> illegal pulses exactly 1 cycle in DECODE, then FETCH beat 0. Reset asserted in RTYPEEX -> no regwrite; restart at fetch. FETCH_BEATS=2 build -> irwrite sequence 01, 10.

Source files
------------

// File: rtl/mc_controller_p.sv
// Multicycle control unit for the 8-bit MIPS datapath.
// Fetches an instruction over FETCH_BEATS byte reads, decodes it and
// sequences execution, driving every mux select, write enable and the
// ALU control word. Memory states stall on mem_ready.
//
// Build option:
//   CTRL_BNE_EN - adds the BNE instruction (opcode 000101). Without it that
//                 opcode is treated as illegal.
//
// state     | meaning
// ----------+--------------------------------------------------------
// FETCH     | read instruction byte <beat>, PC <= PC + 1 per beat
// DECODE    | precompute branch target, dispatch on opcode
// MEMADR    | compute effective address for LB/SB
// MEMRD     | load read, waits for mem_ready
// MEMWB     | write loaded byte to rt
// MEMWR     | store write, waits for mem_ready
// RTYPEEX   | R-type ALU operation
// RTYPEWB   | write ALU result to rd
// BEQEX     | compare, take branch when zero
// BNEEX     | compare, take branch when not zero (CTRL_BNE_EN only)
// ADDIEX    | add immediate
// ADDIWB    | write ALU result to rt
// JEX       | load jump target into PC

module mc_controller_p #(
    parameter int FETCH_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   zero,
    input  logic                   mem_ready,
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    output logic                   memread,
    output logic                   memtoreg,
    output logic                   memwrite,
    output logic                   iord,
    output logic                   alusrcA,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   pcen,
    output logic [1:0]             alusrcB,
    output logic [1:0]             pcsrc,
    output logic [2:0]             alucontrol,
    output logic [FETCH_BEATS-1:0] irwrite,
    output logic                   illegal
);

    localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_BEATS - 1);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
`ifdef CTRL_BNE_EN
        , S_BNEEX
`endif
    } state_t;

    state_t        state, state_nx;
    logic [BW-1:0] beat, beat_nx;
    logic          pcwrite;
    logic          branch;
    logic [1:0]    aluop;
`ifdef CTRL_BNE_EN
    logic          branch_ne;
`endif

    // State and fetch-beat registers; reset restarts at fetch beat 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            beat  <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
        end
    end

    // Next-state and control outputs; everything stays 0 while reset is high.
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        memread  = 1'b0;
        memtoreg = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        alusrcA  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        alusrcB  = 2'b00;
        pcsrc    = 2'b00;
        irwrite  = '0;
        illegal  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
`ifdef CTRL_BNE_EN
        branch_ne = 1'b0;
`endif
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcB = 2'b01;
                    if (mem_ready) begin
                        irwrite = FETCH_BEATS'(1) << beat;
                        pcwrite = 1'b1;
                        if (beat == LAST_BEAT) begin
                            beat_nx  = '0;
                            state_nx = S_DECODE;
                        end else begin
                            beat_nx = beat + BW'(1);
                        end
                    end
                end
                S_DECODE: begin
                    alusrcB = 2'b11;
                    case (op)
                        OP_LB, OP_SB: state_nx = S_MEMADR;
                        OP_RTYPE:     state_nx = S_RTYPEEX;
                        OP_BEQ:       state_nx = S_BEQEX;
`ifdef CTRL_BNE_EN
                        OP_BNE:       state_nx = S_BNEEX;
`endif
                        OP_ADDI:      state_nx = S_ADDIEX;
                        OP_J:         state_nx = S_JEX;
                        default: begin
                            illegal  = 1'b1;
                            state_nx = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrcA  = 1'b1;
                    alusrcB  = 2'b10;
                    state_nx = (op == OP_LB) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) state_nx = S_MEMWB;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    state_nx = S_FETCH;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) state_nx = S_FETCH;
                end
                S_RTYPEEX: begin
                    alusrcA  = 1'b1;
                    aluop    = 2'b10;
                    state_nx = S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    state_nx = S_FETCH;
                end
                S_BEQEX: begin
                    alusrcA  = 1'b1;
                    aluop    = 2'b01;
                    pcsrc    = 2'b01;
                    branch   = 1'b1;
                    state_nx = S_FETCH;
                end
`ifdef CTRL_BNE_EN
                S_BNEEX: begin
                    alusrcA   = 1'b1;
                    aluop     = 2'b01;
                    pcsrc     = 2'b01;
                    branch_ne = 1'b1;
                    state_nx  = S_FETCH;
                end
`endif
                S_ADDIEX: begin
                    alusrcA  = 1'b1;
                    alusrcB  = 2'b10;
                    state_nx = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    state_nx = S_FETCH;
                end
                S_JEX: begin
                    pcsrc    = 2'b10;
                    pcwrite  = 1'b1;
                    state_nx = S_FETCH;
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

    // ALU control word from aluop, with the R-type funct decode.
    always_comb begin
        alucontrol = 3'b000;
        if (!reset) begin
            case (aluop)
                2'b00: alucontrol = 3'b010;
                2'b01: alucontrol = 3'b110;
                default: begin
                    case (funct)
                        6'b100000: alucontrol = 3'b010;
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b010;
                    endcase
                end
            endcase
        end
    end

    // Gated PC enable: unconditional writes plus taken branches.
`ifdef CTRL_BNE_EN
    assign pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);
`else
    assign pcen = pcwrite | (branch & zero);
`endif

endmodule
